hazard_control: RTL

Pipeline hazard controller for the five-stage MIPS datapath. It reads the destination and control fields leaving the DecodeExecute register and the ExecuteMemory register, and compares them against the source registers of the instruction in Decode. It drives the stall enables for PC and IF/ID, and bubble/flush commands for IF/ID, ID/EX and EX/MEM. A small FSM sequences load-use stalls and taken-branch/jump flushes, and two counters record stall and flush cycles for debug readout.

---
 rtl/hazard_control_pkg.sv | 24 ++
 rtl/hazard_compare.sv | 52 +++++
 rtl/hazard_control.sv | 127 ++++++++++++
 3 files changed

// File: rtl/hazard_control_pkg.sv
// ============================================================================
// hazard_control_pkg : shared FSM state and RegDst encodings for hazard logic
// Revision 1.0
// ============================================================================
`default_nettype none

package hazard_control_pkg;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_STALL = 2'd1,
      ST_FLUSH = 2'd2
   } state_e;

   localparam logic [1:0] RD_RT = 2'd0;
   localparam logic [1:0] RD_RD = 2'd1;
   localparam logic [1:0] RD_RA = 2'd2;

   localparam logic [4:0] REG_ZERO = 5'd0;
   localparam logic [4:0] REG_RA   = 5'd31;

endpackage

`default_nettype wire

// File: rtl/hazard_compare.sv
// ============================================================================
// hazard_compare : EX destination select and load-use compare against Decode
// Revision 1.0
// ============================================================================
`default_nettype none

module hazard_compare
   import hazard_control_pkg::*;
#(
   parameter int REG_W = 5
) (
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_uses_rs,
   input  logic             id_uses_rt,
   input  logic             ex_MemRead,
   input  logic             ex_RegWrite,
   input  logic [REG_W-1:0] ex_rt,
   input  logic [REG_W-1:0] ex_rd,
   input  logic [1:0]       ex_RegDst,
   output logic             load_use
);

   localparam logic [REG_W-1:0] C_ZERO = REG_W'(REG_ZERO);
   localparam logic [REG_W-1:0] C_RA   = REG_W'(REG_RA);

   logic [REG_W-1:0] ex_dest;
   logic             has_dest;
   logic             src_hit;

   always_comb begin
      ex_dest  = C_ZERO;
      has_dest = 1'b1;
      case (ex_RegDst)
         RD_RT:   ex_dest = ex_rt;
         RD_RD:   ex_dest = ex_rd;
         RD_RA:   ex_dest = C_RA;
         default: has_dest = 1'b0;
      endcase
   end

   // $zero is never a real producer, so a load into it cannot create a hazard
   always_comb begin
      src_hit  = (id_uses_rs && (id_rs == ex_dest)) ||
                 (id_uses_rt && (id_rt == ex_dest));
      load_use = ex_MemRead && ex_RegWrite && has_dest &&
                 (ex_dest != C_ZERO) && src_hit;
   end

endmodule

`default_nettype wire

// File: rtl/hazard_control.sv
// ============================================================================
// hazard_control : load-use stall and MEM redirect flush sequencing, counters
// Revision 1.0
// ============================================================================
`default_nettype none

module hazard_control
   import hazard_control_pkg::*;
#(
   parameter int NUM_REGS = 32,
   parameter int CNT_W    = 32
) (
   input  logic                        Clk,
   input  logic                        Reset,
   input  logic [$clog2(NUM_REGS)-1:0] id_rs,
   input  logic [$clog2(NUM_REGS)-1:0] id_rt,
   input  logic                        id_uses_rs,
   input  logic                        id_uses_rt,
   input  logic                        ex_MemRead,
   input  logic                        ex_RegWrite,
   input  logic [$clog2(NUM_REGS)-1:0] ex_rt,
   input  logic [$clog2(NUM_REGS)-1:0] ex_rd,
   input  logic [1:0]                  ex_RegDst,
   input  logic                        mem_redirect,
   output logic                        PCWrite,
   output logic                        IFID_Write,
   output logic                        IFID_Flush,
   output logic                        IDEX_Flush,
   output logic                        EXMEM_Flush,
   output logic [CNT_W-1:0]            stall_count,
   output logic [CNT_W-1:0]            flush_count
);

   localparam int              REG_W   = $clog2(NUM_REGS);
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] stall_count_q, stall_count_d;
   logic [CNT_W-1:0] flush_count_q, flush_count_d;
   logic             load_use;

   hazard_compare #(
      .REG_W (REG_W)
   ) u_compare (
      .id_rs       (id_rs),
      .id_rt       (id_rt),
      .id_uses_rs  (id_uses_rs),
      .id_uses_rt  (id_uses_rt),
      .ex_MemRead  (ex_MemRead),
      .ex_RegWrite (ex_RegWrite),
      .ex_rt       (ex_rt),
      .ex_rd       (ex_rd),
      .ex_RegDst   (ex_RegDst),
      .load_use    (load_use)
   );

   always_comb begin
      state_d     = ST_RUN;
      PCWrite     = 1'b1;
      IFID_Write  = 1'b1;
      IFID_Flush  = 1'b0;
      IDEX_Flush  = 1'b0;
      EXMEM_Flush = 1'b0;
      if (!Reset) begin
         IFID_Flush  = 1'b1;
         IDEX_Flush  = 1'b1;
         EXMEM_Flush = 1'b1;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (mem_redirect) begin
                  state_d     = ST_FLUSH;
                  IFID_Flush  = 1'b1;
                  IDEX_Flush  = 1'b1;
                  EXMEM_Flush = 1'b1;
               end else if (load_use) begin
                  state_d    = ST_STALL;
                  PCWrite    = 1'b0;
                  IFID_Write = 1'b0;
                  IDEX_Flush = 1'b1;
               end
            end
            ST_STALL: begin
               if (mem_redirect) begin
                  state_d     = ST_FLUSH;
                  IFID_Flush  = 1'b1;
                  IDEX_Flush  = 1'b1;
                  EXMEM_Flush = 1'b1;
               end
            end
            // Decode and EX hold bubbles here, so neither hazard source is real
            ST_FLUSH: state_d = ST_RUN;
            default:  state_d = ST_RUN;
         endcase
      end
   end

   always_comb begin
      stall_count_d = stall_count_q;
      flush_count_d = flush_count_q;
      if (!PCWrite && (stall_count_q != CNT_MAX)) begin
         stall_count_d = stall_count_q + CNT_ONE;
      end
      if (EXMEM_Flush && (flush_count_q != CNT_MAX)) begin
         flush_count_d = flush_count_q + CNT_ONE;
      end
   end

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state_q       <= ST_RUN;
         stall_count_q <= '0;
         flush_count_q <= '0;
      end else begin
         state_q       <= state_d;
         stall_count_q <= stall_count_d;
         flush_count_q <= flush_count_d;
      end
   end

   assign stall_count = stall_count_q;
   assign flush_count = flush_count_q;

endmodule

`default_nettype wire
